// File: rtl/rep_add_mult_seq_pkg.sv
// -----------------------------------------------------------------------------
// rep_add_mult_seq_pkg
//   Shared definitions for the repeated-addition multiplier: controller state
//   encoding and a small operand-select helper.
// -----------------------------------------------------------------------------
package rep_add_mult_seq_pkg;

    // Controller states; encodings are fixed so other blocks can decode them.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Decide whether operands are swapped at accept time.  A swap puts the
    // smaller operand on the loop counter.  Ties keep a as the multiplicand.
    function automatic logic swap_ops(input logic swap_en, input logic a_lt_b);
        return swap_en & a_lt_b;
    endfunction

endpackage

// File: rtl/rep_add_mult_seq_zero_det.sv
// -----------------------------------------------------------------------------
// zero_det
//   Parametrised zero detector: out is high when every bit of in is clear.
//   Ports:
//     in   [WIDTH-1:0]  value under test
//     out               1 when in == 0
// -----------------------------------------------------------------------------
module zero_det #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in,
    output logic             out
);

    assign out = (in == '0);

endmodule

// File: rtl/rep_add_mult_seq.sv
// -----------------------------------------------------------------------------
// rep_add_mult_seq
//   Sequential unsigned multiplier built from repeated addition.  Operands are
//   captured on start while ready; the multiplicand is then added into the
//   accumulator once per cycle, count times.  With SWAP_MIN=1 the smaller
//   operand becomes the count so the run is as short as possible.  A zero count
//   skips the add loop entirely.
//   Ports:
//     clk      rising-edge clock
//     rst      asynchronous active-high reset
//     start    request, sampled only while ready
//     a, b     WIDTH-bit operands, sampled with start
//     ready    high in IDLE
//     busy     high in ADD
//     done     one-cycle pulse, product valid
//     zero_op  captured loop count was zero (held with product)
//     product  2*WIDTH-bit result, held until the next accepted start
// -----------------------------------------------------------------------------
module rep_add_mult_seq
    import rep_add_mult_seq_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter bit SWAP_MIN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 zero_op,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;

    state_t               state;
    logic [PW-1:0]        acc;
    logic [PW-1:0]        mreg;
    logic [WIDTH-1:0]     cnt;

    // Operand select: count goes to the smaller operand when swapping.
    logic                 swap;
    logic [WIDTH-1:0]     m_sel;
    logic [WIDTH-1:0]     c_sel;
    logic                 c_zero;

    assign swap  = swap_ops(SWAP_MIN, (a < b));
    assign m_sel = swap ? b : a;
    assign c_sel = swap ? a : b;

    zero_det #(.WIDTH(WIDTH)) u_zd_count (
        .in  (c_sel),
        .out (c_zero)
    );

    // The last add is the one where the decremented count reaches zero.
    logic [WIDTH-1:0]     cnt_dec;
    logic                 last_add;

    assign cnt_dec = cnt - 1'b1;

    zero_det #(.WIDTH(WIDTH)) u_zd_cnt (
        .in  (cnt_dec),
        .out (last_add)
    );

    // Accumulator is 2*WIDTH wide; the product of two WIDTH-bit values fits.
    logic [PW-1:0]        sum;

    assign sum = acc + mreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            acc     <= '0;
            mreg    <= '0;
            cnt     <= '0;
            zero_op <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc  <= '0;
                        cnt  <= c_sel;
                        mreg <= {{WIDTH{1'b0}}, m_sel};
                        if (c_zero) begin
                            zero_op <= 1'b1;
                            product <= '0;
                            state   <= S_DONE;
                        end else begin
                            zero_op <= 1'b0;
                            state   <= S_ADD;
                        end
                    end
                end
                S_ADD: begin
                    acc <= sum;
                    cnt <= cnt_dec;
                    if (last_add) begin
                        product <= sum;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs come straight from the state register.
    assign ready = (state == S_IDLE);
    assign busy  = (state == S_ADD);
    assign done  = (state == S_DONE);

endmodule
